blink_rate_ctrl: RTL and testbench
==================================

BLINK_RATE_CTRL -- requirements
Module: blink_rate_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd640000: consecutive stable cycles required to accept a button level change (20 ms at 32 MHz).
REQ-002 Parameter HOLD_CYCLES, default 26'd32000000: debounced-press duration that counts as a long press (1 s at 32 MHz).
REQ-003 Parameters PERIOD0..PERIOD3, defaults 22'd3993608, 22'd1996804, 22'd998402, 22'd499201: blink half-period table, indexed by rate_idx.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-006 btn_  input  1  raw asynchronous pushbutton, active-low (0 = pressed); may bounce.
REQ-007 period  output  22  selected blink half-period in clk cycles, for the downstream blinker divider compare value.
REQ-008 period_load  output  1  one-cycle strobe; downstream reloads its compare value and clears its divider.
REQ-009 rate_idx  output  2  current table index, 0..3.
REQ-010 btn_pressed  output  1  debounced button state, 1 = pressed.

Function
REQ-011 btn_ SHALL pass through a 2-flop synchronizer before any other use; both flops reset to 1.
REQ-012 Debounce: 20-bit counter SHALL clear whenever the synchronized level equals the debounced level, and otherwise increment.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the level still differs, the debounced level SHALL take the synchronized level and the counter SHALL clear in the same cycle.
REQ-014 A single clean btn_ edge SHALL change btn_pressed exactly 2+DEBOUNCE_CYCLES cycles later; any bounce shorter than DEBOUNCE_CYCLES SHALL restart the count and produce no change.
REQ-015 btn_pressed SHALL be the inverse of the debounced level.
REQ-016 FSM states: IDLE (released), PRESSED (timing the press), HELD (long press already served).
REQ-017 IDLE -> PRESSED when btn_pressed rises; the 26-bit hold counter SHALL clear on this transition.
REQ-018 In PRESSED, the hold counter SHALL increment by 1 per cycle and SHALL saturate, never wrap.
REQ-019 PRESSED -> IDLE when btn_pressed falls before the long-press threshold (short press): rate_idx SHALL increment modulo 4 (3 -> 0) and period_load SHALL pulse.
REQ-020 PRESSED -> HELD when the hold counter equals HOLD_CYCLES-1 while still pressed: rate_idx SHALL become 0 and period_load SHALL pulse, even if rate_idx was already 0.
REQ-021 HELD -> IDLE when btn_pressed falls; this release SHALL NOT change rate_idx and SHALL NOT pulse period_load.
REQ-022 If the release and the hold threshold occur in the same cycle, the long-press action (REQ-020) SHALL win and the FSM SHALL go to IDLE.
REQ-023 period, rate_idx and period_load SHALL be registered and SHALL update on the same clock edge; period SHALL equal PERIODn for n = rate_idx at all times.
REQ-024 period_load SHALL be high for exactly one cycle per event and SHALL never be high on two consecutive cycles.
REQ-025 On the first clock edge with reset_ high after reset, period_load SHALL pulse once so downstream loads PERIOD0.

Reset
REQ-026 While reset_ is low at a clock edge, outputs SHALL take: period = PERIOD0, period_load = 0, rate_idx = 0, btn_pressed = 0.
REQ-027 The same edge SHALL set: FSM = IDLE, debounced level = 1, both counters = 0, synchronizer flops = 1.
REQ-028 Reset asserted mid-press or mid-debounce SHALL abandon the operation with no period_load pulse.
REQ-029 After reset, a button held low through reset release SHALL be treated as a new press after 2+DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16)
REQ-030 Reset release with btn_ = 1 -> period_load high for exactly 1 cycle, period = PERIOD0, rate_idx = 0.
REQ-031 btn_ low for 3 cycles then high, repeated 5 times (bounce) -> btn_pressed stays 0, no period_load pulse.
REQ-032 4 clean short presses (low 8 cycles, high 8 cycles) -> rate_idx 1, 2, 3, 0 with one period_load each, period tracking the table; btn_pressed rises 6 cycles after each falling edge of btn_.
REQ-033 rate_idx = 2, btn_ held low 40 cycles -> rate_idx = 0 and period_load pulse exactly 16 cycles after btn_pressed rises; release -> no further pulse.
REQ-034 Release arranged to coincide with the hold threshold -> long-press result rate_idx = 0, FSM ends in IDLE, exactly one period_load.
REQ-035 reset_ driven low for 1 cycle mid-press with rate_idx = 3 -> next cycle rate_idx = 0, period = PERIOD0, btn_pressed = 0; held button re-detected after 6 cycles.

Source files
------------

// File: rtl/blink_rate_ctrl.sv
// Debounced pushbutton that steps a blink half-period table on short presses
// and returns it to entry 0 on a long press.
module blink_rate_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd640000,
  parameter logic [25:0] HOLD_CYCLES     = 26'd32000000,
  parameter logic [21:0] PERIOD0         = 22'd3993608,
  parameter logic [21:0] PERIOD1         = 22'd1996804,
  parameter logic [21:0] PERIOD2         = 22'd998402,
  parameter logic [21:0] PERIOD3         = 22'd499201
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        btn_,
  output logic [21:0] period,
  output logic        period_load,
  output logic [1:0]  rate_idx,
  output logic        btn_pressed
);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_e;

  logic [1:0]  sync_q;
  logic        deb_q, deb_d;
  logic [19:0] cnt_q, cnt_d;
  logic        accept;
  logic        press_evt, release_evt;

  state_e      state_q;
  logic [25:0] hold_q;
  logic [1:0]  rate_idx_q;
  logic [21:0] period_q;
  logic        load_q;
  logic        init_q;

  function automatic logic [21:0] period_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return PERIOD0;
      2'd1:    return PERIOD1;
      2'd2:    return PERIOD2;
      default: return PERIOD3;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], btn_};
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    accept = 1'b0;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
      deb_d  = sync_q[1];
      cnt_d  = '0;
      accept = 1'b1;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // The FSM reacts on the same edge the debounced level changes, keeping it aligned with btn_pressed.
  assign press_evt   = accept & ~sync_q[1];
  assign release_evt = accept &  sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rate_idx_q <= 2'd0;
      period_q   <= PERIOD0;
      load_q     <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      load_q <= init_q;
      init_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_evt) begin
            state_q <= PRESSED;
            hold_q  <= '0;
          end
        end
        PRESSED: begin
          if (hold_q != '1) hold_q <= hold_q + 26'd1;
          // A release landing on the threshold still counts as a long press.
          if (hold_q == HOLD_CYCLES - 26'd1) begin
            state_q    <= release_evt ? IDLE : HELD;
            rate_idx_q <= 2'd0;
            period_q   <= PERIOD0;
            load_q     <= 1'b1;
          end else if (release_evt) begin
            state_q    <= IDLE;
            rate_idx_q <= rate_idx_q + 2'd1;
            period_q   <= period_of(rate_idx_q + 2'd1);
            load_q     <= 1'b1;
          end
        end
        HELD: begin
          if (release_evt) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period      = period_q;
  assign period_load = load_q;
  assign rate_idx    = rate_idx_q;
  assign btn_pressed = ~deb_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl with a scoreboard of expected period_load
// events (index, period, cycle) checked whenever the DUT pulses.
module tb_blink_rate_ctrl;

  localparam logic [21:0] P0 = 22'd3993608;
  localparam logic [21:0] P1 = 22'd1996804;
  localparam logic [21:0] P2 = 22'd998402;
  localparam logic [21:0] P3 = 22'd499201;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        btn_ = 1'b1;
  logic [21:0] period;
  logic        period_load;
  logic [1:0]  rate_idx;
  logic        btn_pressed;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_load = 1'b0;

  typedef struct {
    logic [1:0]  idx;
    logic [21:0] per;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  blink_rate_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .HOLD_CYCLES    (26'd16)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .btn_       (btn_),
    .period     (period),
    .period_load(period_load),
    .rate_idx   (rate_idx),
    .btn_pressed(btn_pressed)
  );

  function automatic logic [21:0] tbl(input logic [1:0] i);
    case (i)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check period consistency and any load pulse against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("period_tracks_idx", {10'd0, period}, {10'd0, tbl(rate_idx)});
    if (period_load) begin
      check("load_not_consecutive", {31'd0, prev_load}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_load", {31'd0, period_load}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("load_idx",    {30'd0, rate_idx}, {30'd0, e.idx});
        check("load_period", {10'd0, period},   {10'd0, e.per});
        check("load_cycle",  cyc,               e.cyc);
      end
    end
    prev_load = period_load;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [1:0] idx, input int delta);
    exp_t e;
    e.idx = idx;
    e.per = tbl(idx);
    e.cyc = cyc + delta;
    sb_q.push_back(e);
  endtask

  // Low 8 cycles, high 8 cycles; the release is accepted 6 edges after btn_ rises.
  task automatic short_press(input logic [1:0] exp_idx);
    btn_ = 1'b0;
    ticks(5);
    check("press_not_yet", {31'd0, btn_pressed}, 32'd0);
    ticks(1);
    check("press_rise", {31'd0, btn_pressed}, 32'd1);
    ticks(2);
    push(exp_idx, 6);
    btn_ = 1'b1;
    ticks(5);
    check("release_not_yet", {31'd0, btn_pressed}, 32'd1);
    ticks(1);
    check("release_fall", {31'd0, btn_pressed}, 32'd0);
    check("short_idx", {30'd0, rate_idx}, {30'd0, exp_idx});
    ticks(2);
  endtask

  initial begin
    // Reset state
    ticks(3);
    check("rst_period", {10'd0, period}, {10'd0, P0});
    check("rst_load", {31'd0, period_load}, 32'd0);
    check("rst_idx", {30'd0, rate_idx}, 32'd0);
    check("rst_pressed", {31'd0, btn_pressed}, 32'd0);

    // Release: one load pulse of PERIOD0
    reset_ = 1'b1;
    push(2'd0, 1);
    ticks(1);
    check("init_load_high", {31'd0, period_load}, 32'd1);
    ticks(1);
    check("init_load_low", {31'd0, period_load}, 32'd0);

    // Bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      btn_ = 1'b0;
      ticks(3);
      btn_ = 1'b1;
      ticks(3);
      check("bounce_pressed", {31'd0, btn_pressed}, 32'd0);
    end
    ticks(4);
    check("bounce_idx", {30'd0, rate_idx}, 32'd0);

    // Four short presses wrap the index 1,2,3,0
    short_press(2'd1);
    short_press(2'd2);
    short_press(2'd3);
    short_press(2'd0);

    // Long press from index 2
    short_press(2'd1);
    short_press(2'd2);
    btn_ = 1'b0;
    ticks(6);
    check("long_rise", {31'd0, btn_pressed}, 32'd1);
    push(2'd0, 16);
    ticks(34);
    btn_ = 1'b1;
    ticks(12);
    check("long_idx", {30'd0, rate_idx}, 32'd0);
    check("long_released", {31'd0, btn_pressed}, 32'd0);

    // Release coincides with the hold threshold
    short_press(2'd1);
    btn_ = 1'b0;
    ticks(6);
    push(2'd0, 16);
    ticks(10);
    btn_ = 1'b1;
    ticks(12);
    check("tie_idx", {30'd0, rate_idx}, 32'd0);
    // A following short press works only if the FSM ended in IDLE
    short_press(2'd1);
    short_press(2'd2);
    short_press(2'd3);

    // Reset mid-press with index 3
    btn_ = 1'b0;
    ticks(8);
    reset_ = 1'b0;
    ticks(1);
    check("midrst_idx", {30'd0, rate_idx}, 32'd0);
    check("midrst_period", {10'd0, period}, {10'd0, P0});
    check("midrst_pressed", {31'd0, btn_pressed}, 32'd0);
    check("midrst_load", {31'd0, period_load}, 32'd0);
    reset_ = 1'b1;
    push(2'd0, 1);
    ticks(5);
    check("redetect_not_yet", {31'd0, btn_pressed}, 32'd0);
    ticks(1);
    check("redetect_rise", {31'd0, btn_pressed}, 32'd1);
    push(2'd1, 6);
    btn_ = 1'b1;
    ticks(12);
    check("post_rst_idx", {30'd0, rate_idx}, 32'd1);

    ticks(4);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
